hazard_unit: RTL and testbench

Pipeline hazard unit for the 5-stage ARM core. It consumes the controller's hazard interface (`RegWriteM`, `MemtoRegE`, `PCWrPendingF`, plus `BranchTakenE`, `RegWriteW`, `PCSrcW`) and register addresses from the datapath. It drives forwarding selects and the stall/flush controls, including `FlushE` back to the controller. It also adds a data-memory wait handshake with a timeout watchdog and saturating stall/flush event counters.

---
 rtl/hazard_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Forwarding, stall/flush control, data-memory wait watchdog and
//            saturating stall/flush event counters for the 5-stage ARM core.
// Revision : 1.0
// ============================================================================
module hazard_unit #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    RA1D,
    input  logic [3:0]    RA2D,
    input  logic [3:0]    RA1E,
    input  logic [3:0]    RA2E,
    input  logic [3:0]    WA3E,
    input  logic [3:0]    WA3M,
    input  logic [3:0]    WA3W,
    input  logic          RegWriteM,
    input  logic          RegWriteW,
    input  logic          MemtoRegE,
    input  logic          BranchTakenE,
    input  logic          PCWrPendingF,
    input  logic          PCSrcW,
    input  logic          MemReqM,
    input  logic          MemReadyM,
    input  logic          CountClr,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushW,
    output logic          MemTimeout,
    output logic [CW-1:0] StallCycles,
    output logic [CW-1:0] FlushCycles
);

    localparam logic [0:0]    S_IDLE    = 1'b0;
    localparam logic [0:0]    S_WAIT    = 1'b1;
    localparam logic [15:0]   c_timeout = 16'(TIMEOUT);
    localparam logic [CW-1:0] c_cntMax  = '1;

    logic        w_m1m, w_m1w, w_m2m, w_m2w;
    logic        w_ldrStall, w_memStall;
    logic [0:0]  r_state, w_nextState;
    logic [15:0] r_waitCnt, w_waitCntNext;
    logic        r_memTimeout;
    logic [CW-1:0] r_stallCycles, r_flushCycles;

    // R15 is the PC and is never forwarded
    assign w_m1m = (RA1E == WA3M) && (RA1E != 4'hF);
    assign w_m1w = (RA1E == WA3W) && (RA1E != 4'hF);
    assign w_m2m = (RA2E == WA3M) && (RA2E != 4'hF);
    assign w_m2w = (RA2E == WA3W) && (RA2E != 4'hF);

    assign w_ldrStall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign w_memStall = MemReqM && !MemReadyM;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (!reset) begin
            if (w_m1m && RegWriteM)      ForwardAE = 2'b10;
            else if (w_m1w && RegWriteW) ForwardAE = 2'b01;
            if (w_m2m && RegWriteM)      ForwardBE = 2'b10;
            else if (w_m2w && RegWriteW) ForwardBE = 2'b01;
            StallF = w_ldrStall || PCWrPendingF || w_memStall;
            StallD = w_ldrStall || w_memStall;
            StallE = w_memStall;
            StallM = w_memStall;
            // A frozen pipeline must not lose instructions to a flush
            FlushD = !w_memStall && (PCWrPendingF || PCSrcW || BranchTakenE);
            FlushE = !w_memStall && (w_ldrStall || BranchTakenE);
            FlushW = w_memStall;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_waitCntNext = r_waitCnt;
        case (r_state)
            S_IDLE: begin
                if (w_memStall) begin
                    w_nextState   = S_WAIT;
                    w_waitCntNext = 16'd1;
                end else begin
                    w_waitCntNext = 16'd0;
                end
            end
            default: begin
                if (w_memStall) begin
                    w_waitCntNext = (r_waitCnt >= c_timeout) ? c_timeout : r_waitCnt + 16'd1;
                end else begin
                    w_nextState   = S_IDLE;
                    w_waitCntNext = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_waitCnt    <= 16'd0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_waitCntNext;
            // Sets once TIMEOUT consecutive stalled cycles have elapsed
            if (w_memStall && (w_waitCntNext == c_timeout))
                r_memTimeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || CountClr) begin
            r_stallCycles <= '0;
            r_flushCycles <= '0;
        end else begin
            if (StallF && (r_stallCycles != c_cntMax))
                r_stallCycles <= r_stallCycles + 1'b1;
            if (FlushE && (r_flushCycles != c_cntMax))
                r_flushCycles <= r_flushCycles + 1'b1;
        end
    end

    assign MemTimeout  = r_memTimeout;
    assign StallCycles = r_stallCycles;
    assign FlushCycles = r_flushCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Directed self-checking bench for hazard_unit (TIMEOUT=4, CW=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic       PCWrPendingF, PCSrcW, MemReqM, MemReadyM, CountClr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [3:0] StallCycles, FlushCycles;

    int tests = 0;
    int fails = 0;

    hazard_unit #(.TIMEOUT(4), .CW(4)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CountClr(CountClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0; BranchTakenE = 1'b0;
        PCWrPendingF = 1'b0; PCSrcW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        CountClr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; PCWrPendingF = 1'b1;
        MemReqM = 1'b1;
        #1;
        tests++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin fails++;
            $display("FAIL reset_stall: got %b expected 0000", {StallF, StallD, StallE, StallM}); end
        tests++; if ({FlushD, FlushE, FlushW} !== 3'b111) begin fails++;
            $display("FAIL reset_flush: got %b expected 111", {FlushD, FlushE, FlushW}); end
        tests++; if (ForwardAE !== 2'b00) begin fails++;
            $display("FAIL reset_fwd: got %b expected 00", ForwardAE); end
        tick(); tick();
        tests++; if ({MemTimeout, StallCycles, FlushCycles} !== 9'd0) begin fails++;
            $display("FAIL reset_regs: got to=%b sc=%0d fc=%0d expected 0", MemTimeout, StallCycles, FlushCycles); end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forwarding();
        RA1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        tests++; if (ForwardAE !== 2'b10) begin fails++;
            $display("FAIL fwd_m_prio: got %b expected 10", ForwardAE); end
        RegWriteM = 1'b0;
        #1;
        tests++; if (ForwardAE !== 2'b01) begin fails++;
            $display("FAIL fwd_w: got %b expected 01", ForwardAE); end
        RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15; RegWriteM = 1'b1;
        #1;
        tests++; if (ForwardAE !== 2'b00) begin fails++;
            $display("FAIL fwd_r15: got %b expected 00", ForwardAE); end
        RA2E = 4'd7; WA3M = 4'd6; WA3W = 4'd7;
        #1;
        tests++; if (ForwardBE !== 2'b01) begin fails++;
            $display("FAIL fwd_b_w: got %b expected 01", ForwardBE); end
        RegWriteW = 1'b0;
        #1;
        tests++; if (ForwardBE !== 2'b00) begin fails++;
            $display("FAIL fwd_b_nowrite: got %b expected 00", ForwardBE); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        CountClr = 1'b1; tick(); CountClr = 1'b0;
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #1;
        tests++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin fails++;
            $display("FAIL load_use: got F/D/FE/FD=%b expected 1110", {StallF, StallD, FlushE, FlushD}); end
        tests++; if ({StallE, StallM, FlushW} !== 3'b000) begin fails++;
            $display("FAIL load_use_em: got %b expected 000", {StallE, StallM, FlushW}); end
        tick();
        idle_inputs();
        #1;
        tests++; if (FlushCycles !== 4'd1) begin fails++;
            $display("FAIL load_use_fcnt: got %0d expected 1", FlushCycles); end
        tests++; if (StallCycles !== 4'd1) begin fails++;
            $display("FAIL load_use_scnt: got %0d expected 1", StallCycles); end
    endtask

    task automatic test_branch_memwait();
        BranchTakenE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
        #1;
        tests++; if ({FlushD, FlushE, FlushW} !== 3'b001) begin fails++;
            $display("FAIL br_wait_flush: got %b expected 001", {FlushD, FlushE, FlushW}); end
        tests++; if ({StallF, StallD, StallE, StallM} !== 4'b1111) begin fails++;
            $display("FAIL br_wait_stall: got %b expected 1111", {StallF, StallD, StallE, StallM}); end
        MemReqM = 1'b0;
        #1;
        tests++; if ({FlushD, FlushE, FlushW} !== 3'b110) begin fails++;
            $display("FAIL br_flush: got %b expected 110", {FlushD, FlushE, FlushW}); end
        tests++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin fails++;
            $display("FAIL br_stall: got %b expected 0000", {StallF, StallD, StallE, StallM}); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        #1;
        tests++; if ({StallF, FlushW} !== 2'b00) begin fails++;
            $display("FAIL ready_first: got %b expected 00", {StallF, FlushW}); end
        tick();
        tests++; if (dut.r_state !== 1'b0) begin fails++;
            $display("FAIL ready_first_state: got %b expected 0", dut.r_state); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            tests++; if (MemTimeout !== (k >= 5)) begin fails++;
                $display("FAIL timeout_cycle%0d: got %b expected %b", k, MemTimeout, (k >= 5)); end
            tick();
        end
        MemReadyM = 1'b1;
        tick();
        tests++; if (MemTimeout !== 1'b1) begin fails++;
            $display("FAIL timeout_sticky: got %b expected 1", MemTimeout); end
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        tests++; if (MemTimeout !== 1'b0) begin fails++;
            $display("FAIL timeout_reset: got %b expected 0", MemTimeout); end
    endtask

    task automatic test_saturation();
        CountClr = 1'b1; tick(); CountClr = 1'b0;
        PCWrPendingF = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        tests++; if (StallCycles !== 4'd15) begin fails++;
            $display("FAIL sat_stall: got %0d expected 15", StallCycles); end
        tests++; if (FlushCycles !== 4'd0) begin fails++;
            $display("FAIL sat_flush: got %0d expected 0", FlushCycles); end
        CountClr = 1'b1; tick(); CountClr = 1'b0;
        tests++; if (StallCycles !== 4'd0) begin fails++;
            $display("FAIL sat_clear: got %0d expected 0", StallCycles); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick(); tick();
        tests++; if (dut.r_state !== 1'b1) begin fails++;
            $display("FAIL midwait_enter: got %b expected 1", dut.r_state); end
        reset = 1'b1;
        #1;
        tests++; if ({FlushE, StallF} !== 2'b10) begin fails++;
            $display("FAIL midwait_rst_out: got %b expected 10", {FlushE, StallF}); end
        tick();
        tests++; if ({dut.r_state, dut.r_waitCnt} !== 17'd0) begin fails++;
            $display("FAIL midwait_state: got st=%b cnt=%0d expected 0", dut.r_state, dut.r_waitCnt); end
        reset = 1'b0;
        tick(); tick(); tick();
        tests++; if (MemTimeout !== 1'b0) begin fails++;
            $display("FAIL midwait_fresh3: got %b expected 0", MemTimeout); end
        tick();
        tests++; if (MemTimeout !== 1'b1) begin fails++;
            $display("FAIL midwait_fresh4: got %b expected 1", MemTimeout); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_memwait();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
